// File: rtl/morph3x3_bin.sv
// 3x3 binary morphology (erosion or dilation) on a 1-bit pixel stream.
//
// The stream's timing and coordinates are re-emitted delayed by LAT = H_TOTAL+2 clocks.
// out_data is the filtered pixel for (out_x, out_y).
//
// Parameters:
//   H_ACTIVE  active pixels per line
//   V_ACTIVE  active lines per frame
//   H_TOTAL   clocks per line including blanking (must match the timing generator)
//   MODE      0 = erosion (AND of 9 taps), 1 = dilation (OR of 9 taps)
//
// Ports:
//   clk, rst             pixel clock, synchronous active-high reset
//   bypass               1 = out_data is in_data delayed by LAT, no filtering or border rule
//   loc_x, loc_y         input pixel coordinate, valid while in_de=1
//   in_hs, in_vs, in_de  input sync (active-low hs/vs) and data enable
//   in_data              input binary pixel
//   out_x .. out_de      inputs delayed by LAT
//   out_data             filtered pixel, forced to 0 while out_de=0
module morph3x3_bin #(
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned V_ACTIVE = 272,
  parameter int unsigned H_TOTAL  = 525,
  parameter int unsigned MODE     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bypass,
  input  logic [9:0] loc_x,
  input  logic [9:0] loc_y,
  input  logic       in_hs,
  input  logic       in_vs,
  input  logic       in_de,
  input  logic       in_data,
  output logic [9:0] out_x,
  output logic [9:0] out_y,
  output logic       out_hs,
  output logic       out_vs,
  output logic       out_de,
  output logic       out_data
);

  localparam int unsigned LAT = H_TOTAL + 2;
  localparam int unsigned AW  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] y;
    logic [9:0] x;
  } stage_t;

  // Panel sync is active-low, so idle stages hold hs/vs high.
  localparam stage_t StageRst = '{hs: 1'b1, vs: 1'b1, de: 1'b0, y: 10'd0, x: 10'd0};

  // ---------------------------------------------------------------------------
  // Sync / coordinate delay line (LAT stages)
  // ---------------------------------------------------------------------------
  stage_t pipe_q [LAT];
  stage_t stage_in;

  always_comb begin
    stage_in    = StageRst;
    stage_in.hs = in_hs;
    stage_in.vs = in_vs;
    stage_in.de = in_de;
    stage_in.y  = loc_y;
    stage_in.x  = loc_x;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LAT; i++) pipe_q[i] <= StageRst;
    end else begin
      pipe_q[0] <= stage_in;
      for (int unsigned i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Raw pixel delayed by LAT-1; the result register supplies the last stage in bypass.
  logic [LAT-2:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= {data_q[LAT-3:0], in_data};
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers: buf1 holds row y-1, buf2 holds row y-2 (not reset)
  // ---------------------------------------------------------------------------
  logic [H_ACTIVE-1:0] buf1_q, buf2_q;
  logic [AW-1:0]       rd_idx;
  logic                x_in_range;
  logic                buf1_rd, buf2_rd;

  always_comb begin
    x_in_range = (loc_x < 10'(H_ACTIVE));
    rd_idx     = loc_x[AW-1:0];
    buf1_rd    = x_in_range ? buf1_q[rd_idx] : 1'b0;
    buf2_rd    = x_in_range ? buf2_q[rd_idx] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (in_de && x_in_range) begin
      buf1_q[rd_idx] <= in_data;
      buf2_q[rd_idx] <= buf1_rd;
    end
  end

  // ---------------------------------------------------------------------------
  // 3x3 window. Column bits are {row y-2, row y-1, row y}.
  // The result must be registered in the same clock that the right-hand column
  // arrives, so the window is evaluated on its next-state value: the two stored
  // columns plus the incoming one. The column that would shift out is never
  // used and so is not stored.
  // ---------------------------------------------------------------------------
  logic [2:0] col_l_q, col_m_q;
  logic [2:0] col_new;
  logic [8:0] taps;

  always_comb begin
    col_new = {buf2_rd, buf1_rd, in_data};
    taps    = {col_l_q, col_m_q, col_new};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_l_q <= '0;
      col_m_q <= '0;
    end else if (in_de) begin
      col_l_q <= col_m_q;
      col_m_q <= col_new;
    end
  end

  // ---------------------------------------------------------------------------
  // Result register. Coordinates for the pixel it lands on come from the stage
  // just before the delay-line output.
  // ---------------------------------------------------------------------------
  stage_t nxt;
  logic   border;
  logic   morph;
  logic   result_d, result_q;

  always_comb begin
    nxt    = pipe_q[LAT-2];
    border = (nxt.x == 10'd0) || (nxt.x >= 10'(H_ACTIVE - 1)) ||
             (nxt.y == 10'd0) || (nxt.y >= 10'(V_ACTIVE - 1));
    morph  = (MODE == 0) ? (&taps) : (|taps);

    result_d = 1'b0;
    if (nxt.de) begin
      if (bypass) begin
        result_d = data_q[LAT-2];
      end else if (!border) begin
        result_d = morph;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= 1'b0;
    end else begin
      result_q <= result_d;
    end
  end

  assign out_x    = pipe_q[LAT-1].x;
  assign out_y    = pipe_q[LAT-1].y;
  assign out_hs   = pipe_q[LAT-1].hs;
  assign out_vs   = pipe_q[LAT-1].vs;
  assign out_de   = pipe_q[LAT-1].de;
  assign out_data = result_q;

endmodule

// File: tb/tb_morph3x3_bin.sv
// Bench for morph3x3_bin. Two reduced-geometry instances (erode, dilate) run full frames of
// patterned and random images checked against a neighbourhood model. A default-geometry
// instance in bypass runs random data alongside to check the 527-clock latency.
module tb_morph3x3_bin;

  localparam int HA = 20, VA = 12, HT = 26, VT = 15, LS = HT + 2;
  localparam int DHA = 480, DVA = 272, DHT = 525, DVT = 288, LD = 527;
  localparam int NFRM = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       s_byp, s_hs, s_vs, s_de, s_d;
  logic [9:0] s_x, s_y;
  logic       d_byp, d_hs, d_vs, d_de, d_d;
  logic [9:0] d_x, d_y;

  logic [9:0] e_x, e_y, g_x, g_y, f_x, f_y;
  logic       e_hs, e_vs, e_de, e_data;
  logic       g_hs, g_vs, g_de, g_data;
  logic       f_hs, f_vs, f_de, f_data;

  morph3x3_bin #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .MODE(0)) u_ero (
    .clk(clk), .rst(rst), .bypass(s_byp), .loc_x(s_x), .loc_y(s_y),
    .in_hs(s_hs), .in_vs(s_vs), .in_de(s_de), .in_data(s_d),
    .out_x(e_x), .out_y(e_y), .out_hs(e_hs), .out_vs(e_vs), .out_de(e_de), .out_data(e_data)
  );

  morph3x3_bin #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .MODE(1)) u_dil (
    .clk(clk), .rst(rst), .bypass(s_byp), .loc_x(s_x), .loc_y(s_y),
    .in_hs(s_hs), .in_vs(s_vs), .in_de(s_de), .in_data(s_d),
    .out_x(g_x), .out_y(g_y), .out_hs(g_hs), .out_vs(g_vs), .out_de(g_de), .out_data(g_data)
  );

  morph3x3_bin u_def (
    .clk(clk), .rst(rst), .bypass(d_byp), .loc_x(d_x), .loc_y(d_y),
    .in_hs(d_hs), .in_vs(d_vs), .in_de(d_de), .in_data(d_d),
    .out_x(f_x), .out_y(f_y), .out_hs(f_hs), .out_vs(f_vs), .out_de(f_de), .out_data(f_data)
  );

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] y;
    logic [9:0] x;
    logic       d;
    logic       byp;
    logic       ok;
  } smp_t;

  smp_t hist_s [1024];
  smp_t hist_d [1024];
  bit   img [VA][HA];

  int checks = 0;
  int errors = 0;
  int since_rst = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Golden pixel: zero on the border, else AND/OR over the 3x3 neighbourhood.
  function automatic logic gold(input int mode, input int cx, input int cy);
    logic acc;
    if (cx < 1 || cx > HA - 2 || cy < 1 || cy > VA - 2) return 1'b0;
    acc = (mode == 0);
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (mode == 0) acc = acc & img[cy+dy][cx+dx];
        else           acc = acc | img[cy+dy][cx+dx];
      end
    end
    return acc;
  endfunction

  task automatic gen_img(input int pat);
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        case (pat)
          0:       img[y][x] = (x == 10 && y == 6);
          1:       img[y][x] = (x >= 5 && x <= 9 && y >= 3 && y <= 7);
          2:       img[y][x] = 1'b1;
          3:       img[y][x] = ($urandom_range(0, 1) == 1);
          4:       img[y][x] = ($urandom_range(0, 9) != 0);
          default: img[y][x] = ($urandom_range(0, 9) == 0);
        endcase
      end
    end
  endtask

  task automatic chk_small(input string nm, input int mode, input int n,
                           input logic [22:0] got_sync, input logic got_d);
    smp_t e;
    if (since_rst < LS) begin
      check($sformatf("%s.rst_sync", nm), 32'(got_sync), 32'({1'b1, 1'b1, 1'b0, 20'd0}));
      check($sformatf("%s.rst_data", nm), 32'(got_d), 32'(0));
    end else begin
      e = hist_s[(n - LS + 1) % 1024];
      check($sformatf("%s.sync", nm), 32'(got_sync), 32'({e.hs, e.vs, e.de, e.y, e.x}));
      if (!e.de) begin
        check($sformatf("%s.blank_data", nm), 32'(got_d), 32'(0));
      end else if (hist_s[n % 1024].byp) begin
        check($sformatf("%s.byp(%0d,%0d)", nm, e.x, e.y), 32'(got_d), 32'(e.d));
      end else if (e.ok) begin
        check($sformatf("%s.pix(%0d,%0d)", nm, e.x, e.y), 32'(got_d),
              32'(gold(mode, int'(e.x), int'(e.y))));
      end
    end
  endtask

  task automatic chk_def(input int n, input logic [22:0] got_sync, input logic got_d);
    smp_t e;
    if (since_rst < LD) begin
      check("def.rst_sync", 32'(got_sync), 32'({1'b1, 1'b1, 1'b0, 20'd0}));
      check("def.rst_data", 32'(got_d), 32'(0));
    end else begin
      e = hist_d[(n - LD + 1) % 1024];
      check("def.sync", 32'(got_sync), 32'({e.hs, e.vs, e.de, e.y, e.x}));
      check("def.byp", 32'(got_d), 32'(e.de ? e.d : 1'b0));
    end
  endtask

  initial begin
    int n, sh, sv, dh, dv, fcnt, frm, fsr, rst_left, t_in, t_out;
    logic prev_dde;
    n = 0; sh = 0; sv = 0; dh = 500; dv = 0;
    fcnt = 0; frm = 0; fsr = 0; rst_left = 0;
    t_in = -1; t_out = -1; prev_dde = 1'b0;
    s_byp = 1'b0; d_byp = 1'b1;

    while (!(fcnt == NFRM && sh == 0 && sv == 0)) begin
      if (sh == 0 && sv == 0) begin
        frm = fcnt;
        fcnt++;
        gen_img(frm % 6);
        fsr++;
      end
      // Reset for 10 clocks in the middle of frame 8.
      if (frm == 8 && sv == 8 && sh == 3) rst_left = 10;
      rst = (n < 5) || (rst_left > 0);
      if (rst_left > 0) rst_left--;
      if (rst) fsr = 0;

      if (sh == 0) s_byp = ($urandom_range(0, 7) == 0);
      s_de = (sh < HA) && (sv < VA);
      s_x  = 10'(sh);
      s_y  = 10'(sv);
      s_hs = !(sh >= HA + 2 && sh < HA + 4);
      s_vs = !(sv == VA + 1);
      s_d  = s_de ? img[sv][sh] : 1'($urandom_range(0, 1));

      d_de = (dh < DHA) && (dv < DVA);
      d_x  = 10'(dh);
      d_y  = 10'(dv);
      d_hs = !(dh >= DHA + 10 && dh < DHA + 20);
      d_vs = !(dv == DVA + 2);
      d_d  = 1'($urandom_range(0, 1));

      @(posedge clk);
      hist_s[n % 1024] = '{hs: s_hs, vs: s_vs, de: s_de, y: s_y, x: s_x, d: s_d,
                           byp: s_byp, ok: (fsr >= 2) && !rst};
      hist_d[n % 1024] = '{hs: d_hs, vs: d_vs, de: d_de, y: d_y, x: d_x, d: d_d,
                           byp: 1'b1, ok: 1'b0};
      since_rst = rst ? 0 : since_rst + 1;
      if (t_in < 0 && n >= 5 && d_de && !prev_dde) t_in = n;
      prev_dde = d_de;

      @(negedge clk);
      chk_small("ero", 0, n, {e_hs, e_vs, e_de, e_y, e_x}, e_data);
      chk_small("dil", 1, n, {g_hs, g_vs, g_de, g_y, g_x}, g_data);
      chk_def(n, {f_hs, f_vs, f_de, f_y, f_x}, f_data);
      if (t_out < 0 && f_de) t_out = n + 1;

      n++;
      sh++;
      if (sh == HT) begin
        sh = 0;
        sv++;
        if (sv == VT) sv = 0;
      end
      dh++;
      if (dh == DHT) begin
        dh = 0;
        dv++;
        if (dv == DVT) dv = 0;
      end
    end

    check("lat527", 32'(t_out - t_in), 32'(LD));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/morph3x3_bin.md
Name: morph3x3_bin

Overview:
- 3x3 binary morphology stage (erosion or dilation) on the 1-bit thresholded pixel stream of the 480-wide LCD pipeline.
- Sits directly upstream of the barcode threshold scanner: it consumes the timing/coordinate stream plus the binary pixel and re-emits the same stream delayed, with the pixel filtered.
- Two instances in series (erode, then dilate) form the opening stage that removes isolated noise before scanning.

Parameters:
- H_ACTIVE, 480, active pixels per line
- V_ACTIVE, 272, active lines per frame
- H_TOTAL, 525, clocks per line including blanking; must match the timing generator
- MODE, 0, 0 = erosion (AND of 9 taps), 1 = dilation (OR of 9 taps)

Ports:
- clk  in  1  pixel clock (lcd_clk)
- rst  in  1  synchronous, active-high reset
- bypass  in  1  1 = pass in_data through unfiltered, with the same latency
- loc_x  in  10  input pixel x, valid when in_de=1
- loc_y  in  10  input pixel y, valid when in_de=1
- in_hs  in  1  input hsync
- in_vs  in  1  input vsync
- in_de  in  1  input data enable
- in_data  in  1  binary pixel (1 = bar, 0 = background)
- out_x  out  10  loc_x delayed by LAT
- out_y  out  10  loc_y delayed by LAT
- out_hs  out  1  in_hs delayed by LAT
- out_vs  out  1  in_vs delayed by LAT
- out_de  out  1  in_de delayed by LAT
- out_data  out  1  filtered pixel for (out_x, out_y)

Behaviour:
- One clock domain, clk. All state uses synchronous active-high reset rst.
- Latency: LAT = H_TOTAL+2 clocks, fixed. With defaults, LAT = 527.
- Sync/coordinate delay line: LAT stages each for hs, vs, de, x and y.
  - On reset, hs/vs stages load 1 (inactive, active-low panel sync).
  - On reset, de, x, y stages load 0.
- Line buffers: two 1-bit x H_ACTIVE buffers (RAM or shift), addressed by loc_x, written only when in_de=1.
  - Buffer 1 holds row y-1; buffer 2 holds row y-2.
  - Line buffers are not reset.
- Window: 3x3 register array.
  - Shifts left by one column only when in_de=1.
  - New column is {buf2[loc_x], buf1[loc_x], in_data}.
  - When in_de=0 the window holds.
- Result register, updated every clock:
  - Interior pixel (1<=out_x<=H_ACTIVE-2 and 1<=out_y<=V_ACTIVE-2): AND (MODE=0) or OR (MODE=1) of all 9 window taps.
  - Border pixel (column 0, column H_ACTIVE-1, row 0, row V_ACTIVE-1): 0.
  - bypass=1: delayed in_data (tap at LAT-1 plus the register), which ignores the border rule.
- Alignment: the result for centre (cx,cy) is computed in the cycle input (cx+1,cy+1) is presented, and is registered so that it lands on the same cycle the delay line presents out_x=cx, out_y=cy.
- out_data is forced to 0 whenever out_de=0.
- Reset behaviour:
  - Outputs take reset values on the clock edge where rst is sampled high.
  - After release, out_de stays 0 for LAT clocks.
  - out_data for the remainder of an interrupted frame and for the first two rows of the next frame is unspecified; it must be 0 or 1, never X.
  - The first complete frame after a full frame of input is bit-exact to the golden model.
- bypass changing mid-frame takes effect on the next output pixel; no glitch on sync outputs.
- MODE is static (elaboration time).

Test Plan:
- Isolated 1 at (100,100), rest 0:
  - MODE=0 -> all out_data 0.
  - MODE=1 -> out_data=1 exactly at x 99..101, y 99..101 (9 pixels); elsewhere 0.
- Solid block x 200..204, y 50..54, MODE=0 -> out_data=1 exactly for x 201..203, y 51..53.
- All-ones frame:
  - MODE=0 -> 1 everywhere except row 0, row 271, column 0, column 479, which are 0.
  - MODE=1 -> same border zeros, interior 1.
- Latency check: first in_de rise at cycle T -> out_de rises at T+527; out_x/out_y equal loc_x/loc_y from 527 cycles earlier for every active pixel; out_hs/out_vs edges shifted by exactly 527.
- bypass=1 with a pseudo-random frame -> out_data(t) = in_data(t-527) for all active pixels, borders included.
- rst high for 10 cycles mid-frame (line 130):
  - Next clock: out_hs=out_vs=1, out_de=0, out_x=out_y=0, out_data=0.
  - out_de stays 0 for 527 clocks after release.
  - Second complete frame matches the golden model.
